// File: rtl/bd2ph_sync_receiver.sv
// Clocked receiving end of a 2-phase bundled-data channel: synchronizes the
// request, captures the bundled word into a show-ahead FIFO and returns the ack.
module bd2ph_sync_receiver #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inR,
    input  logic [WIDTH-1:0] inData,
    output logic             inA,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [CNT_W-1:0] rxCount,
    output logic             fifoFull
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   reqS;
    logic                   pending;
    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;
    logic [AW:0]            count;

    // Phase mismatch between synchronized request and ack means a word waits;
    // the full test uses only the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        reqS     = syncQ[SYNC_STAGES-1];
        pending  = reqS ^ inA;
        fifoFull = (count == FULL_CNT);
        outValid = (count != '0);
        push     = pending & ~fifoFull;
        pop      = outValid & outReady;
        outData  = mem[rdPtr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ   <= '0;
            inA     <= 1'b0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            rxCount <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], inR};
            if (push) begin
                mem[wrPtr] <= inData;
                wrPtr      <= wrPtr + AW'(1);
                inA        <= ~inA;
                rxCount    <= rxCount + CNT_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bd2ph_sync_receiver.sv
// Bench for bd2ph_sync_receiver: directed phases plus randomized sender/sink,
// checked every cycle against a queue-based reference model.
module tb_bd2ph_sync_receiver;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int D  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inR = 1'b0;
    logic [W-1:0]  inData = '0;
    logic          inA;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [W-1:0]  outData;
    logic [CW-1:0] rxCount;
    logic          fifoFull;

    bd2ph_sync_receiver #(.WIDTH(W), .SYNC_STAGES(SS), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .inR(inR), .inData(inData), .inA(inA),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .rxCount(rxCount), .fifoFull(fifoFull)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: sampled request history, ack phase, word queue, counter.
    bit            mSync [SS];
    bit            mAck;
    logic [W-1:0]  mQ [$];
    logic [CW-1:0] mCnt;

    logic [W-1:0]  rcv [$];
    int            ackToggles;
    logic          prevA;
    logic [W-1:0]  sendBase;
    int            sendTotal;
    int            sentCnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit reqS, pend, full, valid, doPop, doPush;
        if (!rst && outValid === 1'b1 && outReady) rcv.push_back(outData);
        if (rst) begin
            foreach (mSync[i]) mSync[i] = 1'b0;
            mAck = 1'b0;
            mQ.delete();
            mCnt = '0;
        end else begin
            reqS   = mSync[SS-1];
            pend   = reqS ^ mAck;
            full   = (mQ.size() == D);
            valid  = (mQ.size() != 0);
            doPop  = valid && outReady;
            doPush = pend && !full;
            if (doPop) void'(mQ.pop_front());
            if (doPush) begin
                mQ.push_back(inData);
                mAck = ~mAck;
                mCnt = mCnt + 1'b1;
            end
            for (int i = SS - 1; i > 0; i--) mSync[i] = mSync[i-1];
            mSync[0] = inR;
        end
        @(posedge clk);
        #2;
        if (inA !== prevA) ackToggles++;
        prevA = inA;
        check("inA", inA, mAck);
        check("outValid", outValid, mQ.size() != 0);
        check("fifoFull", fifoFull, mQ.size() == D);
        check("rxCount", rxCount, mCnt);
        if (mQ.size() != 0) check("outData", outData, mQ[0]);
    endtask

    // mode 0: always ready, 1: random ready, 2: never ready
    task automatic cycleStep(input int mode);
        case (mode)
            0:       outReady = 1'b1;
            1:       outReady = 1'($urandom_range(0, 1));
            default: outReady = 1'b0;
        endcase
        if (!rst && sentCnt < sendTotal && inR === inA && (mode == 0 || $urandom_range(0, 2) != 0)) begin
            inData = sendBase + W'(sentCnt);
            inR    = ~inR;
            sentCnt++;
        end
        tick();
    endtask

    task automatic startSend(input logic [W-1:0] base, input int n);
        sendBase   = base;
        sendTotal  = n;
        sentCnt    = 0;
        ackToggles = 0;
        rcv.delete();
    endtask

    task automatic runUntilReceived(input string tag, input int n, input int mode);
        int cyc = 0;
        while (rcv.size() < n && cyc < n * 30 + 100) begin
            cycleStep(mode);
            cyc++;
        end
        check({tag, "_count"}, rcv.size(), n);
    endtask

    task automatic checkOrder(input string tag, input logic [W-1:0] base, input int n);
        int bad = 0;
        foreach (rcv[i]) if (rcv[i] !== base + W'(i)) bad++;
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        int e;
        logic [W-1:0] rb;
        foreach (mSync[i]) mSync[i] = 1'b0;
        mAck = 1'b0;
        mCnt = '0;
        prevA = 1'b0;
        startSend('0, 0);

        // Reset
        rst = 1'b1; outReady = 1'b1;
        tick(); tick();
        check("rst_outData", outData, 0);
        check("rst_inA", inA, 0);
        rst = 1'b0;

        // 1: single word, 3-edge ack latency
        startSend(32'hA5A5_0001, 1);
        e = 0;
        do begin cycleStep(0); e++; end while (inA !== 1'b1 && e < 10);
        check("t1_latency", e, 3);
        runUntilReceived("t1", 1, 0);
        checkOrder("t1", 32'hA5A5_0001, 1);
        check("t1_rxCount", rxCount, 1);

        // 2: ten words streamed
        startSend(32'h10, 10);
        runUntilReceived("t2", 10, 0);
        checkOrder("t2", 32'h10, 10);
        check("t2_rxCount", rxCount, 11);
        check("t2_acks", ackToggles, 10);

        // 3: back-pressure with 6 offered
        startSend(32'h0, 6);
        repeat (40) cycleStep(2);
        check("t3_captured", rxCount, 15);
        check("t3_full", fifoFull, 1);
        check("t3_acks", ackToggles, 4);
        runUntilReceived("t3", 6, 0);
        checkOrder("t3", 32'h0, 6);
        check("t3_acks_total", ackToggles, 6);

        // 4: preload 2 then stream 20 across pointer wrap
        startSend(32'h100, 22);
        e = 0;
        while (mQ.size() < 2 && e < 60) begin cycleStep(2); e++; end
        check("t4_preload", outValid, 1);
        runUntilReceived("t4", 22, 0);
        checkOrder("t4", 32'h100, 22);

        // 5: reset with 3 words held and inR high
        if (inR === 1'b1) begin
            startSend(32'h4F, 1);
            runUntilReceived("t5pre", 1, 0);
        end
        startSend(32'h50, 3);
        e = 0;
        while (!(sentCnt == 3 && inA === inR) && e < 80) begin cycleStep(2); e++; end
        check("t5_held", rxCount, mCnt);
        check("t5_inR", inR, 1);
        rst = 1'b1; outReady = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_outValid", outValid, 0);
        check("t5_inA", inA, 0);
        check("t5_rxCount", rxCount, 0);
        e = 0;
        do begin cycleStep(2); e++; end while (rxCount !== 1 && e < 10);
        check("t5_latency", e, 3);
        repeat (6) cycleStep(2);
        check("t5_once", rxCount, 1);
        startSend(32'h0, 0);
        runUntilReceived("t5", 1, 0);
        rb = 32'h52;
        check("t5_data", rcv[0], rb);

        // 6: counter wrap
        e = (1 << CW) - int'(mCnt);
        startSend(32'h600, e);
        runUntilReceived("t6", e, 0);
        checkOrder("t6", 32'h600, e);
        check("t6_wrap", rxCount, 0);

        // Random sender pacing and sink readiness
        rb = $urandom;
        startSend(rb, 60);
        runUntilReceived("rnd", 60, 1);
        checkOrder("rnd", rb, 60);
        check("rnd_acks", ackToggles, 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bd2ph_sync_receiver.md
Name: bd2ph_sync_receiver

Overview:
- Synchronous receiving end of a 2-phase bundled-data channel. An asynchronous click/delay-element pipeline drives `inR` and `inData`, with the request path delay-matched so data settles before `inR` toggles.
- The block synchronizes `inR`, captures `inData` into a small FIFO and toggles `inA` back to the sender.
- It presents words on a clocked valid/ready interface.
- It is the boundary where matched-delay async stages hand off to clocked logic.

Parameters:
- WIDTH, 32, data word width.
- SYNC_STAGES, 2, flops in the `inR` synchronizer chain (legal values ≥2).
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the received-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- inR  input  1  2-phase request from the async sender; each toggle means one new word.
- inData  input  WIDTH  bundled data; stable from before the `inR` toggle until the matching `inA` toggle.
- inA  output  1  2-phase acknowledge; toggles once per captured word.
- outValid  output  1  FIFO head is valid.
- outReady  input  1  downstream accepts the head.
- outData  output  WIDTH  FIFO head word (show-ahead).
- rxCount  output  CNT_W  words captured since reset; wraps modulo 2^CNT_W.
- fifoFull  output  1  FIFO holds DEPTH words.

Behaviour:
- Reset values (applied at a clk edge while `rst`=1):
  - sync chain = 0, `inA`=0, FIFO empty.
  - `outValid`=0, `outData`=0, `rxCount`=0, `fifoFull`=0.
- Synchronizer: `reqS` is the last stage of the SYNC_STAGES-flop chain clocked from `inR`. No logic sits between stages.
- Pending: pending = `reqS` XOR `inA`. No edge detector is used; phase mismatch alone means a word is waiting.
- Capture: on a clk edge with pending=1 and FIFO not full:
  - write `inData` at the write pointer;
  - toggle `inA`;
  - increment `rxCount`.
- Capture occurs at most once per cycle. After the capture, pending drops to 0 until the sender toggles `inR` again.
- Latency:
  - `inR` toggles before edge k, so stage 1 captures at k and `reqS` changes at edge k+SYNC_STAGES-1.
  - Capture and `inA` toggle occur at edge k+SYNC_STAGES.
  - `outValid` rises after that same edge if the FIFO was empty.
  - Default: 3 edges from `inR` toggle to `inA` toggle.
- Back-pressure:
  - FIFO full with pending=1: no capture, `inA` holds, and the sender stalls naturally.
  - The full test uses the registered count only. A pop in the same cycle does not permit a capture; the capture happens on the following edge.
- Pop: on a clk edge with `outValid`=1 and `outReady`=1, advance the read pointer. `outData` shows the next entry in the same cycle the pointer advances.
- Simultaneous push and pop, FIFO neither full nor empty: count is unchanged and both pointers advance.
- Simultaneous push and pop, FIFO empty: only the push occurs; `outValid` rises next cycle.
- Pointers: log2(DEPTH) bits wrapping naturally. Occupancy count is log2(DEPTH)+1 bits.
- `outReady` while `outValid`=0: ignored.
- `outData` when empty: holds the last-read entry; it is don't-care for checking.
- `rxCount` wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation:
  - FIFO contents are dropped and `inA`=0.
  - If `inR` is still 1 after reset, pending asserts once the synchronizer fills and one word is captured. The system must reset the async sender on the same `rst`.
- No combinational path from `inR`/`inData` to any output; all outputs are registered or FIFO-read.

Test Plan:
1. Reset with `inR`=0, then a single `inR` 0→1 with `inData`=0xA5A5_0001 and `outReady`=1 → `inA` 0→1 exactly 3 edges after the toggle; `outValid` for 1 cycle with `outData`=0xA5A5_0001; `rxCount`=1.
2. Sender model issues 10 words (0x10..0x19), each `inR` toggle issued 1 cycle after `inA` matches; `outReady`=1 → all 10 emerge in order with no duplicates; `rxCount`=10; `inA` toggled 10 times.
3. `outReady`=0 with 6 words offered → 4 captured, `fifoFull`=1, `inA` stops after the 4th toggle; raise `outReady` → remaining 2 captured (the first of them one edge after the first pop), order 0..5 intact.
4. FIFO holding 2 words, pending push with `outReady`=1 → occupancy stays 2, read and write pointers both advance, data order correct across pointer wrap (run 20 words).
5. Assert `rst` for 1 cycle while FIFO holds 3 words and `inR`=1 → next cycle `outValid`=0, `inA`=0, `rxCount`=0; if `inR` is held at 1, exactly one capture follows 3 edges after reset release.
6. Preload `rxCount` to 0xFFFF via 65535 transfers (or accelerated sender), one more word → `rxCount`=0x0000, data intact.
